// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the data-memory store responder and its write buffer.
// DMEM_TOHOST_EN (top level) enables the completion-register decode.
package mips_mem_pkg;

  localparam int WORD_W = 32;
  localparam int DEFAULT_ADDR_W = 6;
  localparam int DEFAULT_DEPTH = 4;
  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'd84;

  // Entry index width follows the package default word-address width.
  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] idx;
    logic [WORD_W-1:0]         data;
  } wbuf_entry_t;

endpackage

// File: rtl/store_fifo.sv
// Posted-store write buffer: circular FIFO that also presents every slot, oldest first,
// with per-slot valid bits so the top level can forward loads from pending stores.
module store_fifo
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  wbuf_entry_t                   din,
  output wbuf_entry_t [DEPTH-1:0]       entries,
  output logic        [DEPTH-1:0]       valid,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  wbuf_entry_t      mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // Slot k is the k-th oldest entry; a higher k is younger.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entries[k] = mem[rd_ptr + PTR_W'(k)];
      valid[k]   = ((PTR_W+1)'(k) < count);
    end
  end

endmodule

// File: rtl/dmem_store_responder.sv
// Data-port responder: posts stores into a write buffer draining into a word RAM,
// forwards loads from pending stores. DMEM_TOHOST_EN adds the tohost completion register.
module dmem_store_responder
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH       = DEFAULT_DEPTH,
  parameter int          ADDR_W      = DEFAULT_ADDR_W,
  parameter logic [31:0] TOHOST_ADDR = DEFAULT_TOHOST_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] tohost_data
);

  logic [ADDR_W-1:0]         idx;
  wbuf_entry_t               push_entry;
  wbuf_entry_t [DEPTH-1:0]   entries;
  logic        [DEPTH-1:0]   valid;
  logic                      full;
  logic                      empty;
  logic                      drain;
  logic                      accept;
  logic [WORD_W-1:0]         ram [2**ADDR_W];
  logic                      unused_adr;

  assign idx        = dataadr[ADDR_W+1:2];
  assign unused_adr = ^{dataadr[31:ADDR_W+2], dataadr[1:0]};

  // A load owns the single RAM port for the whole cycle, so it blocks the drain.
  assign drain  = ~empty & ~memread;
  assign accept = memwrite & (~full | drain);
  assign stall  = memwrite & ~accept;

  assign push_entry.idx  = idx;
  assign push_entry.data = writedata;

  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .pop     (drain),
    .din     (push_entry),
    .entries (entries),
    .valid   (valid),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (drain) ram[entries[0].idx] <= entries[0].data;
  end

  // Oldest to youngest so the youngest matching entry overrides.
  always_comb begin
    readdata = ram[idx];
    for (int k = 0; k < DEPTH; k++) begin
      if (valid[k] && (entries[k].idx == idx)) readdata = entries[k].data;
    end
  end

`ifdef DMEM_TOHOST_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done        <= 1'b0;
      tohost_data <= '0;
    end else if (accept && (dataadr == TOHOST_ADDR)) begin
      done        <= 1'b1;
      tohost_data <= writedata;
    end
  end
`else
  assign done        = 1'b0;
  assign tohost_data = '0;
`endif

endmodule

// File: tb/tb_dmem_store_responder.sv
// Scoreboard bench for dmem_store_responder: driver queues expected stall/readdata per request,
// a negedge monitor pops and compares.
module tb_dmem_store_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        stall;
  logic        done;
  logic [31:0] tohost_data;

`ifdef DMEM_TOHOST_EN
  localparam bit TOHOST_EN = 1'b1;
`else
  localparam bit TOHOST_EN = 1'b0;
`endif

  dmem_store_responder dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .memread     (memread),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .readdata    (readdata),
    .stall       (stall),
    .done        (done),
    .tohost_data (tohost_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_rd;
    logic [31:0] rd;
    bit          st;
    int          tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input bit mr, input bit mw, input logic [31:0] adr, input logic [31:0] wd,
                      input bit chk_rd, input logic [31:0] rd, input bit st, input int tag);
    @(posedge clk);
    #1;
    memread   = mr;
    memwrite  = mw;
    dataadr   = adr;
    writedata = wd;
    if (mr || mw) q.push_back('{chk_rd, rd, st, tag});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 0);
  endtask

  always @(negedge clk) begin
    if (reset && (memread || memwrite)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow actual=empty required=entry");
      end else begin
        e = q.pop_front();
        check32($sformatf("stall[%0d]", e.tag), {31'd0, stall}, {31'd0, e.st});
        if (e.chk_rd) check32($sformatf("readdata[%0d]", e.tag), readdata, e.rd);
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check32("rst_stall", {31'd0, stall}, 32'd0);
    check32("rst_done", {31'd0, done}, 32'd0);
    check32("rst_tohost", tohost_data, 32'd0);
    reset = 1'b1;

    // tohost capture
    step(1'b0, 1'b1, 32'd84, 32'd7, 1'b0, 32'd0, 1'b0, 60);
    idle();
    check32("tohost_done", {31'd0, done}, {31'd0, TOHOST_EN});
    check32("tohost_data", tohost_data, TOHOST_EN ? 32'd7 : 32'd0);

    // Wrap: ten stores, no loads, then read every word back from RAM
    for (int i = 1; i <= 10; i++)
      step(1'b0, 1'b1, 32'(4 * i), 32'(100 + i), 1'b0, 32'd0, 1'b0, i);
    idle();
    idle();
    check32("wrap_count", 32'(dut.u_fifo.count), 32'd0);
    for (int i = 1; i <= 10; i++)
      step(1'b1, 1'b0, 32'(4 * i), 32'd0, 1'b1, 32'(100 + i), 1'b0, 10 + i);

    // Forwarding: RAM[21] holds 55, buffered 7 must win until drained
    step(1'b0, 1'b1, 32'd84, 32'd55, 1'b0, 32'd0, 1'b0, 21);
    idle();
    idle();
    step(1'b1, 1'b0, 32'd84, 32'd0, 1'b1, 32'd55, 1'b0, 22);
    step(1'b0, 1'b1, 32'd84, 32'd7, 1'b0, 32'd0, 1'b0, 23);
    step(1'b1, 1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b0, 24);
    idle();
    step(1'b1, 1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b0, 25);

    // Youngest wins; incoming store is never forwarded
    step(1'b1, 1'b1, 32'd40, 32'd1, 1'b1, 32'd110, 1'b0, 31);
    step(1'b1, 1'b1, 32'd40, 32'd2, 1'b1, 32'd1, 1'b0, 32);
    step(1'b1, 1'b1, 32'd40, 32'd3, 1'b1, 32'd2, 1'b0, 33);
    step(1'b1, 1'b0, 32'd40, 32'd0, 1'b1, 32'd3, 1'b0, 34);
    repeat (5) idle();
    check32("young_count", 32'(dut.u_fifo.count), 32'd0);
    step(1'b1, 1'b0, 32'd40, 32'd0, 1'b1, 32'd3, 1'b0, 35);

    // Full: stall on the fifth store, then push+pop at full
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b1, 32'(120 + 4 * k), 32'(200 + k), 1'b0, 32'd0, 1'b0, 40 + k);
    step(1'b1, 1'b1, 32'd136, 32'd204, 1'b0, 32'd0, 1'b1, 44);
    step(1'b0, 1'b1, 32'd136, 32'd204, 1'b0, 32'd0, 1'b0, 45);
    idle();
    check32("full_count", 32'(dut.u_fifo.count), 32'd4);
    repeat (5) idle();
    for (int k = 0; k < 5; k++)
      step(1'b1, 1'b0, 32'(120 + 4 * k), 32'd0, 1'b1, 32'(200 + k), 1'b0, 46 + k);

    // Mid-run reset with three pending entries
    step(1'b1, 1'b1, 32'd4, 32'd900, 1'b1, 32'd101, 1'b0, 51);
    step(1'b1, 1'b1, 32'd8, 32'd901, 1'b1, 32'd102, 1'b0, 52);
    step(1'b1, 1'b1, 32'd12, 32'd902, 1'b1, 32'd103, 1'b0, 53);
    @(posedge clk);
    #1;
    check32("pre_rst_count", 32'(dut.u_fifo.count), 32'd3);
    reset     = 1'b0;
    memread   = 1'b1;
    memwrite  = 1'b1;
    dataadr   = 32'd4;
    writedata = 32'd999;
    #1;
    check32("mid_rst_stall", {31'd0, stall}, 32'd0);
    check32("mid_rst_done", {31'd0, done}, 32'd0);
    check32("mid_rst_tohost", tohost_data, 32'd0);
    check32("mid_rst_readdata", readdata, 32'd101);
    check32("mid_rst_count", 32'(dut.u_fifo.count), 32'd0);
    @(posedge clk);
    #1;
    check32("mid_rst_readdata2", readdata, 32'd101);
    memread  = 1'b0;
    memwrite = 1'b0;
    reset    = 1'b1;
    repeat (3) idle();
    step(1'b1, 1'b0, 32'd4, 32'd0, 1'b1, 32'd101, 1'b0, 61);
    step(1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 32'd102, 1'b0, 62);
    step(1'b1, 1'b0, 32'd12, 32'd0, 1'b1, 32'd103, 1'b0, 63);
    step(1'b1, 1'b0, 32'd40, 32'd0, 1'b1, 32'd3, 1'b0, 64);
    step(1'b1, 1'b0, 32'd84, 32'd0, 1'b1, 32'd7, 1'b0, 65);
    idle();

    for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
